pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_pkg.sv | 16 +
 rtl/pipe_skid_reg_if.sv | 24 ++
 rtl/pipe_perf_cnt.sv | 23 ++
 rtl/pipe_skid_reg.sv | 106 ++++++++++
 tb/tb_pipe_skid_reg.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: the occupancy state used by skid-buffered
// stages such as pipe_skid_reg.
package pipe_pkg;

  // EMPTY: nothing held; ONE: main entry valid; TWO: main and skid both valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  function automatic logic state_has_data(input state_e s);
    return (s != EMPTY);
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for one pipe_skid_reg stage: upstream in_* channel and
// downstream out_* channel. master = the side feeding the stage and sinking it.
interface pipe_skid_reg_if #(
  parameter int DATA_W = 32
);
  // A beat moves on a rising clk edge when valid & ready are both high; valid
  // and data must be held by the producer until that edge, ready may toggle freely.
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter: increments on inc_i, sticks at all-ones, never wraps.
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with fully registered in_ready_o.
// Define PIPE_PERF_CNT_EN to build the saturating downstream-stall counter.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q;
  logic              in_ready_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid_i & in_ready_q;
  assign out_xfer = out_valid_q & out_ready_i;

  // Flush clears only occupancy; payload registers keep their contents.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data_i;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_data_i;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Handshake outputs are flops loaded from the next state, so in_ready_o
  // never depends combinationally on out_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= state_has_data(state_d);
      in_ready_q  <= (state_d != TWO);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  assign stall_inc = out_valid_q & ~out_ready_i;

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random
// traffic, with an in-order scoreboard and an occupancy/stall reference model.
module tb_pipe_skid_reg;
  import pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam int STALL_MAX = (1 << CNT_W) - 1;
`else
  localparam int STALL_MAX = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_skid_reg_if #(.DATA_W(DATA_W)) bus ();

  pipe_skid_reg #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (bus.in_valid),
    .in_ready_o  (bus.in_ready),
    .in_data_i   (bus.in_data),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (bus.out_data),
    .stall_cnt_o (stall_cnt)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [DATA_W-1:0] exp_q[$];
  int exp_stall = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_stall = 0;
    end else begin
      check_eq("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
      check_eq("in_ready", 64'(bus.in_ready), 64'(exp_q.size() < 2));
      check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
      if (exp_q.size() != 0)
        check_eq("out_data", 64'(bus.out_data), 64'(exp_q[0]));
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0)
        void'(exp_q.pop_front());
      if (bus.out_valid && !bus.out_ready && exp_stall < STALL_MAX)
        exp_stall++;
      if (flush)
        exp_q.delete();
      else if (bus.in_valid && bus.in_ready)
        exp_q.push_back(bus.in_data);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Loads two entries with the sink stalled, leaving the stage full.
  task automatic fill_two(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = a;
    step();
    bus.in_data   = b;
    step();
    bus.in_valid  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    do_reset();

    // Reset values
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_data", 64'(bus.out_data), 64'd0);
    check_eq("rst_stall", 64'(stall_cnt), 64'd0);

    // Single beat, one-cycle latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    step();
    bus.in_valid  = 1'b0;
    check_eq("lat_valid", 64'(bus.out_valid), 64'd1);
    check_eq("lat_data", 64'(bus.out_data), 64'hDEADBEEF);
    check_eq("lat_stall", 64'(stall_cnt), 64'd0);
    step();

    // Skid fill then drain in order
    fill_two(32'd1, 32'd2);
    check_eq("two_state", 64'(dut.state_q), 64'(TWO));
    check_eq("two_in_ready", 64'(bus.in_ready), 64'd0);
    check_eq("two_head", 64'(bus.out_data), 64'd1);
    bus.out_ready = 1'b1;
    step();
    check_eq("drain_second", 64'(bus.out_data), 64'd2);
    check_eq("drain_second_v", 64'(bus.out_valid), 64'd1);
    step();
    check_eq("drain_empty", 64'(bus.out_valid), 64'd0);

    // Back-to-back streaming
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DATA_W'(i);
      step();
      check_eq("b2b_ready", 64'(bus.in_ready), 64'd1);
      check_eq("b2b_data", 64'(bus.out_data), 64'(i));
    end
    bus.in_valid = 1'b0;
    step();

    // Flush while full, with a same-cycle incoming beat
    fill_two(32'h11, 32'h22);
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h00000BAD;
    step();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("flush_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_ready", 64'(bus.in_ready), 64'd1);
    check_eq("flush_keep_main", 64'(bus.out_data), 64'h11);
    check_eq("flush_keep_skid", 64'(dut.skid_q), 64'h22);
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Stall counter saturation
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5A5A5A5A;
    step();
    bus.in_valid  = 1'b0;
    repeat (20) step();
    check_eq("stall_sat", 64'(stall_cnt), 64'(STALL_MAX));
    bus.out_ready = 1'b1;
    step();
    check_eq("stall_hold", 64'(stall_cnt), 64'(STALL_MAX));

    // Reset beats flush while full
    fill_two(32'hAA, 32'hBB);
    rst           = 1'b1;
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hCC;
    step();
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    check_eq("rf_state", 64'(dut.state_q), 64'(EMPTY));
    check_eq("rf_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rf_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rf_data", 64'(bus.out_data), 64'd0);
    check_eq("rf_skid", 64'(dut.skid_q), 64'd0);
    check_eq("rf_stall", 64'(stall_cnt), 64'd0);

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = $urandom;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 31) == 0);
      step();
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (4) step();
    check_eq("drain_done", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
